// File: rtl/time_set_unit_if.sv
// Signal bundle between the time-set unit and its host: set-mode control,
// raw push buttons, running-time load bus, edited time and commit strobe.
interface time_set_unit_if;
    logic       set_en;
    logic       btn_min_n;
    logic       btn_hour_n;
    logic [3:0] cur_h1;
    logic [3:0] cur_h0;
    logic [3:0] cur_m1;
    logic [3:0] cur_m0;
    logic       cur_pm;
    logic [3:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
    logic       pm;
    logic       commit;

    modport master (
        output set_en, btn_min_n, btn_hour_n,
        output cur_h1, cur_h0, cur_m1, cur_m0, cur_pm,
        input  h1, h0, m1, m0, pm, commit
    );

    modport slave (
        input  set_en, btn_min_n, btn_hour_n,
        input  cur_h1, cur_h0, cur_m1, cur_m0, cur_pm,
        output h1, h0, m1, m0, pm, commit
    );
endinterface

// File: rtl/time_set_unit.sv
// Time-set unit: debounced minute/hour buttons edit a BCD time captured on set entry.
// Build option TIME_SET_AUTO_REPEAT_EN adds hold-to-auto-repeat to both buttons.
//
// Button FSM states:
//   state     | meaning
//   ST_IDLE   | button released, waiting for a debounced press
//   ST_HOLD   | pressed, timing the initial auto-repeat delay (auto-repeat build)
//   ST_REPEAT | held past the delay, stepping at the repeat rate (auto-repeat build)
//   ST_HELD   | pressed, one increment issued, waiting for release (single-step build)
module time_set_unit #(
    parameter int          MODE_24H        = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 1000,
    parameter int unsigned REPEAT_RATE     = 250
) (
    input  logic           clk_i,
    input  logic           reset_i,
    time_set_unit_if.slave tsu
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DEBOUNCE_CYCLES - 1);

`ifdef TIME_SET_AUTO_REPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam logic [RPT_W-1:0] DELAY_LOAD = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LOAD  = RPT_W'(REPEAT_RATE - 1);
    localparam int ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [ST_W-1:0] ST_HOLD   = 2'd1;
    localparam logic [ST_W-1:0] ST_REPEAT = 2'd2;
`else
    localparam int ST_W = 1;
    localparam logic [ST_W-1:0] ST_IDLE = 1'b0;
    localparam logic [ST_W-1:0] ST_HELD = 1'b1;
`endif

    localparam logic [3:0] H1_RST = (MODE_24H != 0) ? 4'd0 : 4'd1;
    localparam logic [3:0] H0_RST = (MODE_24H != 0) ? 4'd0 : 4'd2;

    logic [1:0] btn_n_w;
    logic [1:0] inc_w;

    assign btn_n_w = {tsu.btn_hour_n, tsu.btn_min_n};

    // Index 0 = minute button, index 1 = hour button.
    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic            sync1_q;
        logic            sync2_q;
        logic            db_q;
        logic            armed_q;
        logic [DB_W-1:0] db_cnt_q;
        logic [ST_W-1:0] st_q;
        logic [ST_W-1:0] st_d;
        logic            accept_w;
        logic            press_w;
        logic            release_w;
        logic            inc_d;

        // Synchroniser resets to "pressed" so a button held through reset is never
        // armed until a real released level has been observed.
        assign accept_w  = (sync2_q != db_q) && (db_cnt_q == '0);
        assign press_w   = accept_w && !sync2_q && armed_q;
        assign release_w = accept_w && sync2_q;

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                sync1_q  <= 1'b0;
                sync2_q  <= 1'b0;
                db_q     <= 1'b1;
                armed_q  <= 1'b0;
                db_cnt_q <= DB_LOAD;
            end else begin
                sync1_q <= btn_n_w[b];
                sync2_q <= sync1_q;
                if (sync2_q) begin
                    armed_q <= 1'b1;
                end
                if ((sync2_q == db_q) || accept_w) begin
                    db_cnt_q <= DB_LOAD;
                end else begin
                    db_cnt_q <= db_cnt_q - DB_W'(1);
                end
                if (accept_w) begin
                    db_q <= sync2_q;
                end
            end
        end

`ifdef TIME_SET_AUTO_REPEAT_EN
        logic [RPT_W-1:0] rpt_cnt_q;
        logic [RPT_W-1:0] rpt_cnt_d;

        always_comb begin
            st_d      = st_q;
            rpt_cnt_d = rpt_cnt_q;
            inc_d     = 1'b0;
            case (st_q)
                ST_IDLE: begin
                    if (press_w) begin
                        inc_d     = 1'b1;
                        st_d      = ST_HOLD;
                        rpt_cnt_d = DELAY_LOAD;
                    end
                end
                ST_HOLD: begin
                    if (release_w) begin
                        st_d = ST_IDLE;
                    end else if (rpt_cnt_q == '0) begin
                        inc_d     = 1'b1;
                        st_d      = ST_REPEAT;
                        rpt_cnt_d = RATE_LOAD;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q - RPT_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (release_w) begin
                        st_d = ST_IDLE;
                    end else if (rpt_cnt_q == '0) begin
                        inc_d     = 1'b1;
                        rpt_cnt_d = RATE_LOAD;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q - RPT_W'(1);
                    end
                end
                default: st_d = ST_IDLE;
            endcase
        end

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                st_q      <= ST_IDLE;
                rpt_cnt_q <= '0;
            end else begin
                st_q      <= st_d;
                rpt_cnt_q <= rpt_cnt_d;
            end
        end
`else
        always_comb begin
            st_d  = st_q;
            inc_d = 1'b0;
            case (st_q)
                ST_IDLE: begin
                    if (press_w) begin
                        inc_d = 1'b1;
                        st_d  = ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (release_w) begin
                        st_d = ST_IDLE;
                    end
                end
                default: st_d = ST_IDLE;
            endcase
        end

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                st_q <= ST_IDLE;
            end else begin
                st_q <= st_d;
            end
        end
`endif

        assign inc_w[b] = inc_d;
    end

`ifndef TIME_SET_AUTO_REPEAT_EN
    // Repeat timing has no effect in the single-step build; zero values are tolerated.
    if ((REPEAT_DELAY == 0) && (REPEAT_RATE == 0)) begin : g_no_repeat_timing
    end
`endif

    logic       set_en_q;
    logic       commit_q;
    logic       load_w;
    logic       inc_min_w;
    logic       inc_hour_w;
    logic       min_legal_w;
    logic       hour_legal_w;
    logic [3:0] h1_q, h0_q, m1_q, m0_q;
    logic [3:0] h1_d, h0_d, m1_d, m0_d;
    logic       pm_q, pm_d;

    assign load_w     = tsu.set_en && !set_en_q;
    assign inc_min_w  = inc_w[0] && tsu.set_en && !load_w;
    assign inc_hour_w = inc_w[1] && tsu.set_en && !load_w;

    assign min_legal_w = (m1_q <= 4'd5) && (m0_q <= 4'd9);

    always_comb begin
        if (MODE_24H != 0) begin
            hour_legal_w = (h0_q <= 4'd9) &&
                           ((h1_q <= 4'd1) || ((h1_q == 4'd2) && (h0_q <= 4'd3)));
        end else begin
            hour_legal_w = ((h1_q == 4'd0) && (h0_q >= 4'd1) && (h0_q <= 4'd9)) ||
                           ((h1_q == 4'd1) && (h0_q <= 4'd2));
        end
    end

    // Out-of-range captured values fall back to the field minimum on the next step.
    always_comb begin
        m1_d = m1_q;
        m0_d = m0_q;
        if (load_w) begin
            m1_d = tsu.cur_m1;
            m0_d = tsu.cur_m0;
        end else if (inc_min_w) begin
            if (!min_legal_w || ((m1_q == 4'd5) && (m0_q == 4'd9))) begin
                m1_d = 4'd0;
                m0_d = 4'd0;
            end else if (m0_q == 4'd9) begin
                m1_d = m1_q + 4'd1;
                m0_d = 4'd0;
            end else begin
                m0_d = m0_q + 4'd1;
            end
        end
    end

    always_comb begin
        h1_d = h1_q;
        h0_d = h0_q;
        pm_d = pm_q;
        if (load_w) begin
            h1_d = tsu.cur_h1;
            h0_d = tsu.cur_h0;
            pm_d = (MODE_24H != 0) ? 1'b0 : tsu.cur_pm;
        end else if (inc_hour_w) begin
            if (MODE_24H != 0) begin
                if (!hour_legal_w || ((h1_q == 4'd2) && (h0_q == 4'd3))) begin
                    h1_d = 4'd0;
                    h0_d = 4'd0;
                end else if (h0_q == 4'd9) begin
                    h1_d = h1_q + 4'd1;
                    h0_d = 4'd0;
                end else begin
                    h0_d = h0_q + 4'd1;
                end
            end else begin
                if (!hour_legal_w || ((h1_q == 4'd1) && (h0_q == 4'd2))) begin
                    h1_d = 4'd0;
                    h0_d = 4'd1;
                end else if ((h1_q == 4'd1) && (h0_q == 4'd1)) begin
                    h0_d = 4'd2;
                    pm_d = !pm_q;
                end else if (h0_q == 4'd9) begin
                    h1_d = 4'd1;
                    h0_d = 4'd0;
                end else begin
                    h0_d = h0_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            set_en_q <= 1'b0;
            commit_q <= 1'b0;
            h1_q     <= H1_RST;
            h0_q     <= H0_RST;
            m1_q     <= 4'd0;
            m0_q     <= 4'd0;
            pm_q     <= 1'b0;
        end else begin
            set_en_q <= tsu.set_en;
            commit_q <= set_en_q && !tsu.set_en;
            h1_q     <= h1_d;
            h0_q     <= h0_d;
            m1_q     <= m1_d;
            m0_q     <= m0_d;
            pm_q     <= pm_d;
        end
    end

    assign tsu.h1     = h1_q;
    assign tsu.h0     = h0_q;
    assign tsu.m1     = m1_q;
    assign tsu.m0     = m0_q;
    assign tsu.pm     = pm_q;
    assign tsu.commit = commit_q;

endmodule
